// File: rtl/ms_timer_bank_if.sv
// Control/status bus of ms_timer_bank: per-channel arm/disarm, mode, period and status.
// MS_TIMER_STICKY_EN adds the sticky done flags and their clear strobes.
interface ms_timer_bank_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned MS_W   = 16
);
  logic                     enable;
  logic [NUM_CH-1:0]        start;
  logic [NUM_CH-1:0]        stop;
  logic [NUM_CH-1:0]        periodic;
  logic [NUM_CH*MS_W-1:0]   period_ms;
  logic [NUM_CH-1:0]        running;
  logic [NUM_CH-1:0]        expired;
  logic [NUM_CH*MS_W-1:0]   elapsed_ms;
`ifdef MS_TIMER_STICKY_EN
  logic [NUM_CH-1:0]        done_clr;
  logic [NUM_CH-1:0]        done;

  modport master (
    output enable, start, stop, periodic, period_ms, done_clr,
    input  running, expired, elapsed_ms, done
  );

  modport slave (
    input  enable, start, stop, periodic, period_ms, done_clr,
    output running, expired, elapsed_ms, done
  );
`else
  modport master (
    output enable, start, stop, periodic, period_ms,
    input  running, expired, elapsed_ms
  );

  modport slave (
    input  enable, start, stop, periodic, period_ms,
    output running, expired, elapsed_ms
  );
`endif
endinterface

// File: rtl/ms_timer_bank.sv
// Bank of NUM_CH one-shot/periodic millisecond timers sharing one clock-to-ms prescaler.
// Optional feature macro: MS_TIMER_STICKY_EN (sticky per-channel done flags).
module ms_timer_bank #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned MS_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  ms_timer_bank_if.slave bus
);

  localparam int unsigned PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_MS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic              ms_tick;

  state_e            state_q   [NUM_CH];
  state_e            state_d   [NUM_CH];
  logic [MS_W-1:0]   elapsed_q [NUM_CH];
  logic [MS_W-1:0]   elapsed_d [NUM_CH];
  logic [MS_W-1:0]   period_q  [NUM_CH];
  logic [MS_W-1:0]   period_d  [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] expired_q, expired_d;

  logic [MS_W-1:0]   pms_c [NUM_CH];
  logic [NUM_CH-1:0] kill_c, arm_c, adv_c, last_c;

  logic [NUM_CH-1:0]      running_c;
  logic [NUM_CH*MS_W-1:0] elapsed_c;

  // Shared prescaler; frozen while enable is low, never realigned by start.
  always_comb begin
    presc_d = presc_q;
    if (bus.enable) begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    end
  end

  assign ms_tick = bus.enable && (presc_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Per-channel event decode, priority stop > start > tick.
  always_comb begin
    kill_c = '0;
    arm_c  = '0;
    adv_c  = '0;
    last_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pms_c[i]  = bus.period_ms[i*MS_W +: MS_W];
      kill_c[i] = bus.stop[i] || (bus.start[i] && (pms_c[i] == '0));
      arm_c[i]  = !bus.stop[i] && bus.start[i] && (pms_c[i] != '0);
      adv_c[i]  = (state_q[i] == RUN) && ms_tick && !bus.stop[i] && !bus.start[i];
      last_c[i] = adv_c[i] && (elapsed_q[i] == (period_q[i] - MS_W'(1)));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // FSM next-state logic; only one-shot channels drop to IDLE on completion.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      if (kill_c[i]) begin
        state_d[i] = IDLE;
      end else if (arm_c[i]) begin
        state_d[i] = RUN;
      end else if (last_c[i] && !mode_q[i]) begin
        state_d[i] = IDLE;
      end
    end
  end

  // FSM output/datapath logic: elapsed count, latched period/mode, expiry pulse.
  always_comb begin
    mode_d    = mode_q;
    expired_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elapsed_d[i] = elapsed_q[i];
      period_d[i]  = period_q[i];
      if (kill_c[i]) begin
        elapsed_d[i] = '0;
      end else if (arm_c[i]) begin
        elapsed_d[i] = '0;
        period_d[i]  = pms_c[i];
        mode_d[i]    = bus.periodic[i];
      end else if (last_c[i]) begin
        elapsed_d[i] = '0;
        expired_d[i] = 1'b1;
      end else if (adv_c[i]) begin
        elapsed_d[i] = elapsed_q[i] + MS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= '0;
      expired_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        elapsed_q[i] <= '0;
        period_q[i]  <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      expired_q <= expired_d;
      for (int i = 0; i < NUM_CH; i++) begin
        elapsed_q[i] <= elapsed_d[i];
        period_q[i]  <= period_d[i];
      end
    end
  end

  // Flatten per-channel registers onto the bus.
  always_comb begin
    running_c = '0;
    elapsed_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      running_c[i]                = (state_q[i] == RUN);
      elapsed_c[i*MS_W +: MS_W]   = elapsed_q[i];
    end
  end

  assign bus.running    = running_c;
  assign bus.expired    = expired_q;
  assign bus.elapsed_ms = elapsed_c;

`ifdef MS_TIMER_STICKY_EN
  logic [NUM_CH-1:0] done_q, done_d;

  // Set on the same edge that raises expired; a coincident clear loses.
  always_comb begin
    done_d = (done_q & ~bus.done_clr) | expired_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_ms_timer_bank.sv
// Directed, table-driven bench for ms_timer_bank with NUM_CH=2, CLKS_PER_MS=4, MS_W=4.
module tb_ms_timer_bank;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CPM    = 4;
  localparam int unsigned MS_W   = 4;

  logic clk = 1'b0;
  logic reset;

  ms_timer_bank_if #(.NUM_CH(NUM_CH), .MS_W(MS_W)) bus ();

  ms_timer_bank #(
    .NUM_CH(NUM_CH),
    .CLKS_PER_MS(CPM),
    .MS_W(MS_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       en;
    logic [1:0] st;
    logic [1:0] sp;
    logic [1:0] pr;
    logic [7:0] pms;
    logic [1:0] run;
    logic [1:0] ex;
    logic [7:0] ela;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] pr,
                              input logic [7:0] pms, input logic en, input logic [1:0] run,
                              input logic [1:0] ex, input logic [7:0] ela);
    vec_t v;
    v.st = st; v.sp = sp; v.pr = pr; v.pms = pms; v.en = en;
    v.run = run; v.ex = ex; v.ela = ela;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enable    = 1'b1;
    bus.start     = '0;
    bus.stop      = '0;
    bus.periodic  = '0;
    bus.period_ms = '0;
`ifdef MS_TIMER_STICKY_EN
    bus.done_clr  = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] st, input logic [7:0] pms, input logic [1:0] pr);
    bus.start     = st;
    bus.period_ms = pms;
    bus.periodic  = pr;
    step();
    bus.start     = '0;
    bus.period_ms = '0;
    bus.periodic  = '0;
  endtask

  task automatic wait_exp(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.expired[ch] && n < max);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.enable    = tbl[i].en;
      bus.start     = tbl[i].st;
      bus.stop      = tbl[i].sp;
      bus.periodic  = tbl[i].pr;
      bus.period_ms = tbl[i].pms;
      step();
      check($sformatf("%s[%0d].run", name, i), 32'(bus.running), 32'(tbl[i].run));
      check($sformatf("%s[%0d].exp", name, i), 32'(bus.expired), 32'(tbl[i].ex));
      check($sformatf("%s[%0d].ela", name, i), 32'(bus.elapsed_ms), 32'(tbl[i].ela));
    end
    idle();
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, cnt, mx, wrap, prev;
    int e1 [11];

    // Reset state
    do_reset();
    check("reset.run", 32'(bus.running), 0);
    check("reset.exp", 32'(bus.expired), 0);
    check("reset.ela", 32'(bus.elapsed_ms), 0);

    // One-shot ch0 period 3, started with prescaler at 0
    e1 = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h03, 1'b1, 2'b01, 2'b00, 8'h00));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b01, 2'b00, 8'(e1[k])));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b01, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    run_table("oneshot");

    // start+stop together, zero period, zero-period restart acting as stop
    do_reset();
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 8'h03, 1'b1, 2'b00, 2'b00, 8'h00));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 2'b10, 8'h20, 1'b1, 2'b10, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    run_table("edge");

    // Restart ch0 at elapsed=2 with period 1
    do_reset();
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h03, 1'b1, 2'b01, 2'b00, 8'h00));
    for (int k = 0; k < 7; k++)
      tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b01, 2'b00, 8'(e1[k])));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h01, 1'b1, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b01, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b01, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00));
    run_table("restart");

    // Periodic ch1 period 2: first pulse 7 edges after start, then every 8
    do_reset();
    pulse_start(2'b10, 8'h20, 2'b10);
    wait_exp(1, 40, n);
    check("per.first", n, 7);
    for (int k = 0; k < 2; k++) begin
      wait_exp(1, 40, n);
      check($sformatf("per.gap%0d", k), n, 8);
      check($sformatf("per.run%0d", k), 32'(bus.running[1]), 1);
      check($sformatf("per.ela%0d", k), 32'(bus.elapsed_ms[7:4]), 0);
    end
    bus.stop = 2'b10;
    step();
    bus.stop = 2'b00;
    check("per.stop.run", 32'(bus.running), 0);
    check("per.stop.ela", 32'(bus.elapsed_ms), 0);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (bus.expired != 2'b00) cnt++;
    end
    check("per.stop.quiet", cnt, 0);

    // enable low for 5 cycles delays a period-3 one-shot by exactly 5
    do_reset();
    pulse_start(2'b01, 8'h03, 2'b00);
    for (int k = 0; k < 3; k++) step();
    bus.enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.expired != 2'b00) cnt++;
    end
    bus.enable = 1'b1;
    wait_exp(0, 30, n);
    check("en.delay", 3 + 5 + n, 16);
    check("en.quiet", cnt, 0);

    // Period 15 (maximum): 59 edges, elapsed peaks at 14, never wraps
    do_reset();
    pulse_start(2'b01, 8'h0F, 2'b00);
    n = 0; mx = 0; wrap = 0; prev = 0;
    do begin
      step();
      n++;
      if (!bus.expired[0]) begin
        if (int'(bus.elapsed_ms[3:0]) < prev) wrap++;
        prev = int'(bus.elapsed_ms[3:0]);
        if (prev > mx) mx = prev;
      end
    end while (!bus.expired[0] && n < 80);
    check("p15.latency", n, 59);
    check("p15.max_ela", mx, 14);
    check("p15.wrap", wrap, 0);
    check("p15.run", 32'(bus.running[0]), 0);

    // Reset mid-operation aborts all channels silently
    do_reset();
    pulse_start(2'b11, 8'h23, 2'b10);
    for (int k = 0; k < 8; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst.run", 32'(bus.running), 0);
    check("midrst.exp", 32'(bus.expired), 0);
    check("midrst.ela", 32'(bus.elapsed_ms), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.expired != 2'b00) cnt++;
    end
    check("midrst.quiet", cnt, 0);

`ifdef MS_TIMER_STICKY_EN
    // Sticky done: set by expiry, held, cleared by done_clr; set beats clear
    do_reset();
    check("sticky.init", 32'(bus.done), 0);
    pulse_start(2'b01, 8'h01, 2'b00);
    wait_exp(0, 20, n);
    check("sticky.lat", n, 3);
    check("sticky.set", 32'(bus.done[0]), 1);
    for (int k = 0; k < 4; k++) step();
    check("sticky.hold", 32'(bus.done[0]), 1);
    bus.done_clr = 2'b01;
    step();
    bus.done_clr = 2'b00;
    check("sticky.clr", 32'(bus.done[0]), 0);
    bus.done_clr = 2'b01;
    pulse_start(2'b01, 8'h01, 2'b00);
    check("sticky.clr_held", 32'(bus.done[0]), 0);
    wait_exp(0, 20, n);
    check("sticky.setwins", 32'(bus.done[0]), 1);
    bus.done_clr = 2'b00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
